// File: rtl/jh_adc_sine_meter.sv
// jh_adc_sine_meter: windowed max / min / peak-to-peak / overrange meter for one 14-bit ADC channel.
// Define JH_ADC_AVG_EN to publish the mean peak-to-peak of every 4 windows instead of each window.
module jh_adc_sine_meter #(
   parameter int WINDOW     = 100,
   parameter int SETTLE_CYC = 16
) (
   input  logic        CLOCK_50,
   input  logic        ADC_rst_n,
   input  logic [13:0] ADC_in,
   input  logic        ADC_OTR,
   input  logic        meas_en,
   output logic [13:0] peak_max,
   output logic [13:0] peak_min,
   output logic [13:0] amp_pp,
   output logic        otr_flag,
   output logic        meas_valid,
   output logic        busy
);

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_MEAS   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [13:0]      r_adc_q;
   logic             r_otr_q;
   logic [13:0]      cur_max_q, cur_min_q;
   logic             cur_otr_q;
   logic [13:0]      peak_max_q, peak_min_q, amp_pp_q;
   logic             otr_flag_q, valid_q, busy_q;
   logic [13:0]      win_pp;
`ifdef JH_ADC_AVG_EN
   logic [1:0]       grp_q;
   logic [15:0]      sum_q;
`endif

   assign win_pp = cur_max_q - cur_min_q;

   // SETTLE holds for SETTLE_CYC+1 edges, so SETTLE_CYC=0 still costs one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (meas_en) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!meas_en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == SET_LAST) begin
               state_d = ST_MEAS;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_MEAS: begin
            if (!meas_en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = meas_en ? ST_MEAS : ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!ADC_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         r_adc_q    <= '0;
         r_otr_q    <= 1'b0;
         cur_max_q  <= '0;
         cur_min_q  <= '0;
         cur_otr_q  <= 1'b0;
         peak_max_q <= '0;
         peak_min_q <= '0;
         amp_pp_q   <= '0;
         otr_flag_q <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef JH_ADC_AVG_EN
         grp_q      <= '0;
         sum_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_adc_q <= ADC_in;
         r_otr_q <= ADC_OTR;
         busy_q  <= (state_q != ST_IDLE);
         valid_q <= 1'b0;

         if (state_q == ST_MEAS && meas_en) begin
            if (cnt_q == '0) begin
               cur_max_q <= r_adc_q;
               cur_min_q <= r_adc_q;
               cur_otr_q <= r_otr_q;
            end else begin
               if (r_adc_q > cur_max_q) cur_max_q <= r_adc_q;
               if (r_adc_q < cur_min_q) cur_min_q <= r_adc_q;
               cur_otr_q <= cur_otr_q | r_otr_q;
            end
         end

`ifdef JH_ADC_AVG_EN
         if (state_q == ST_IDLE) begin
            grp_q <= '0;
            sum_q <= '0;
         end else if (state_q == ST_DONE) begin
            if (grp_q == 2'd3) begin
               peak_max_q <= cur_max_q;
               peak_min_q <= cur_min_q;
               otr_flag_q <= cur_otr_q;
               amp_pp_q   <= 14'((sum_q + 16'(win_pp)) >> 2);
               valid_q    <= 1'b1;
               grp_q      <= '0;
               sum_q      <= '0;
            end else begin
               grp_q <= grp_q + 1'b1;
               sum_q <= sum_q + 16'(win_pp);
            end
         end
`else
         if (state_q == ST_DONE) begin
            peak_max_q <= cur_max_q;
            peak_min_q <= cur_min_q;
            otr_flag_q <= cur_otr_q;
            amp_pp_q   <= win_pp;
            valid_q    <= 1'b1;
         end
`endif
      end
   end

   assign peak_max   = peak_max_q;
   assign peak_min   = peak_min_q;
   assign amp_pp     = amp_pp_q;
   assign otr_flag   = otr_flag_q;
   assign meas_valid = valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_jh_adc_sine_meter.sv
// Scoreboard bench for jh_adc_sine_meter (default build: per-window results).
module tb_jh_adc_sine_meter;

   localparam int WIN = 100;
   localparam int SET = 16;
   localparam int JUNK = 16383;

   logic        CLOCK_50 = 1'b0;
   logic        ADC_rst_n = 1'b0;
   logic [13:0] ADC_in = '0;
   logic        ADC_OTR = 1'b0;
   logic        meas_en = 1'b0;
   logic [13:0] peak_max, peak_min, amp_pp;
   logic        otr_flag, meas_valid, busy;

   jh_adc_sine_meter #(.WINDOW(WIN), .SETTLE_CYC(SET)) dut (
      .CLOCK_50   (CLOCK_50),
      .ADC_rst_n  (ADC_rst_n),
      .ADC_in     (ADC_in),
      .ADC_OTR    (ADC_OTR),
      .meas_en    (meas_en),
      .peak_max   (peak_max),
      .peak_min   (peak_min),
      .amp_pp     (amp_pp),
      .otr_flag   (otr_flag),
      .meas_valid (meas_valid),
      .busy       (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int mx;
      int mn;
      int pp;
      int otr;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   exp_t last_e;
   int   vcyc[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   win_v[WIN];
   bit   win_o[WIN];

   always @(posedge CLOCK_50) cyc++;

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Every meas_valid consumes one expected window from the scoreboard.
   always @(posedge CLOCK_50) begin
      #1;
      if (meas_valid === 1'b1) begin
         vcyc.push_back(cyc);
         if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("peak_max", int'(peak_max), mon_e.mx);
            chk("peak_min", int'(peak_min), mon_e.mn);
            chk("amp_pp",   int'(amp_pp),   mon_e.pp);
            chk("otr_flag", int'(otr_flag), mon_e.otr);
         end
      end
   end

   task automatic drive(input int a, input bit o, input bit en);
      @(negedge CLOCK_50);
      ADC_in  = 14'(a);
      ADC_OTR = o;
      meas_en = en;
   endtask

   // Enable edge plus settle fillers; returns the edge number where meas_en is sampled.
   task automatic start_run(output int t0);
      drive(JUNK, 1'b1, 1'b1);
      t0 = cyc + 1;
      repeat (SET) drive(JUNK, 1'b1, 1'b1);
   endtask

   // Window samples, then the unused DONE-entry sample.
   task automatic send_window();
      exp_t e;
      e.mx = 0; e.mn = 16383; e.otr = 0;
      for (int i = 0; i < WIN; i++) begin
         if (win_v[i] > e.mx) e.mx = win_v[i];
         if (win_v[i] < e.mn) e.mn = win_v[i];
         if (win_o[i]) e.otr = 1;
         drive(win_v[i], win_o[i], 1'b1);
      end
      e.pp = e.mx - e.mn;
      sbq.push_back(e);
      last_e = e;
      drive(JUNK, 1'b1, 1'b1);
   endtask

   // meas_en falls during DONE: that window still reports.
   task automatic end_run();
      drive(JUNK, 1'b1, 1'b0);
      repeat (4) drive(JUNK, 1'b1, 1'b0);
   endtask

   task automatic fill_rand(input int lo, input int hi);
      for (int i = 0; i < WIN; i++) begin
         win_v[i] = int'($urandom_range(hi, lo));
         win_o[i] = 1'b0;
      end
   endtask

   initial begin
      int  t0;
      real v;
      int  s;

      repeat (3) drive(0, 1'b0, 1'b0);
      @(posedge CLOCK_50); #1;
      chk("rst_peak_max", int'(peak_max), 0);
      chk("rst_peak_min", int'(peak_min), 0);
      chk("rst_amp_pp", int'(amp_pp), 0);
      chk("rst_otr", int'(otr_flag), 0);
      chk("rst_valid", int'(meas_valid), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge CLOCK_50);
      ADC_rst_n = 1'b1;
      repeat (2) drive(0, 1'b0, 1'b0);

      // Constant mid-scale: start-up latency and window cadence.
      for (int i = 0; i < WIN; i++) begin win_v[i] = 8192; win_o[i] = 1'b0; end
      start_run(t0);
      send_window();
      send_window();
      end_run();
      chk("const_valid_count", vcyc.size(), 2);
      if (vcyc.size() == 2) begin
         chk("first_latency", vcyc[0] - t0, 118);
         chk("cadence", vcyc[1] - vcyc[0], WIN + 1);
      end
      vcyc.delete();

      // Full-scale sine, then overrange window, then clean window.
      start_run(t0);
      for (int i = 0; i < WIN; i++) begin
         v = 8191.5 + 8191.5 * $sin(6.283185307179586 * real'(i) / real'(WIN));
         s = $rtoi(v + 0.5);
         if (s < 0) s = 0;
         if (s > 16383) s = 16383;
         win_v[i] = s;
         win_o[i] = 1'b0;
      end
      send_window();
      fill_rand(4000, 12000);
      win_o[50] = 1'b1;
      send_window();
      fill_rand(4000, 12000);
      send_window();
      end_run();
      chk("sine_otr_valid_count", vcyc.size(), 3);
      vcyc.delete();

      // Abort at window sample 60: no report, outputs hold, busy drops two edges later.
      start_run(t0);
      for (int i = 0; i < 60; i++) drive(5000 + i, 1'b0, 1'b1);
      drive(1, 1'b1, 1'b0);
      @(posedge CLOCK_50); #1;
      chk("abort_busy_edge1", int'(busy), 1);
      @(posedge CLOCK_50); #1;
      chk("abort_busy_edge2", int'(busy), 0);
      repeat (5) drive(0, 1'b0, 1'b0);
      chk("abort_no_valid", vcyc.size(), 0);
      chk("abort_hold_max", int'(peak_max), last_e.mx);
      chk("abort_hold_min", int'(peak_min), last_e.mn);
      chk("abort_hold_pp", int'(amp_pp), last_e.pp);

      // Re-enable: full start-up again.
      for (int i = 0; i < WIN; i++) begin win_v[i] = 3000 + 7 * i; win_o[i] = 1'b0; end
      start_run(t0);
      send_window();
      end_run();
      chk("reen_valid_count", vcyc.size(), 1);
      if (vcyc.size() == 1) chk("reen_latency", vcyc[0] - t0, 118);
      vcyc.delete();

      // Reset at window sample 40.
      start_run(t0);
      for (int i = 0; i < 40; i++) drive(2000 + i, 1'b0, 1'b1);
      @(negedge CLOCK_50);
      ADC_in = 14'd2040;
      ADC_rst_n = 1'b0;
      meas_en = 1'b0;
      @(posedge CLOCK_50); #1;
      chk("mid_rst_max", int'(peak_max), 0);
      chk("mid_rst_min", int'(peak_min), 0);
      chk("mid_rst_pp", int'(amp_pp), 0);
      chk("mid_rst_otr", int'(otr_flag), 0);
      chk("mid_rst_valid", int'(meas_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      @(negedge CLOCK_50);
      ADC_rst_n = 1'b1;
      repeat (3) drive(0, 1'b0, 1'b0);
      chk("post_rst_idle_busy", int'(busy), 0);
      chk("post_rst_no_valid", vcyc.size(), 0);

      repeat (3) @(negedge CLOCK_50);
      chk("sb_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jh_adc_sine_meter.md
# jh_adc_sine_meter

Measures the amplitude of the sine returned on an ADC channel, the receive-side counterpart of the DAC sine generator. It sits after the ADC sample register and processes one 14-bit unsigned sample per clock. Over a fixed window of one sine period it tracks the maximum, the minimum and the peak-to-peak value, plus a sticky overrange flag. Results are published with a one-cycle valid strobe for the gain-control and monitoring logic.

## Interface
Parameters:
- `WINDOW`, default 100: samples per measurement window (one period of the 500 kHz tone at 50 MHz); legal range 2..1023.
- `SETTLE_CYC`, default 16: samples discarded after enable before the first window; legal range 0..255.

Ports (one clock; reset is synchronous and active-low):
- `CLOCK_50`, input, 1: sole clock; all logic on its rising edge.
- `ADC_rst_n`, input, 1: synchronous active-low reset.
- `ADC_in`, input, 14: unsigned offset-binary ADC sample (mid-scale 8192).
- `ADC_OTR`, input, 1: ADC out-of-range indicator, aligned with `ADC_in`.
- `meas_en`, input, 1: level enable; measurement runs while high.
- `peak_max`, output, 14: maximum sample of the last completed window.
- `peak_min`, output, 14: minimum sample of the last completed window.
- `amp_pp`, output, 14: `peak_max - peak_min`; averaged when `JH_ADC_AVG_EN` is defined.
- `otr_flag`, output, 1: at least one `ADC_OTR` sample occurred in the last completed window.
- `meas_valid`, output, 1: one-cycle strobe when the outputs update.
- `busy`, output, 1: high in SETTLE, MEASURE and DONE.

## Operation
- Input stage: `ADC_in` and `ADC_OTR` are registered every cycle into `r_adc` and `r_otr`. All processing uses these registered values.
- State machine:
  - IDLE: waits for `meas_en`=1, then goes to SETTLE.
  - SETTLE: counts `SETTLE_CYC` samples, then goes to MEASURE. With `SETTLE_CYC`=0, SETTLE is left after one cycle.
  - MEASURE: accumulates `WINDOW` samples, then goes to DONE.
  - DONE: lasts one cycle. It latches the outputs and pulses `meas_valid`. Next state is MEASURE with a fresh window if `meas_en`=1, otherwise IDLE.
- Window logic:
  - The first sample of a window loads `cur_max` and `cur_min` directly.
  - Each later sample updates them with unsigned compares. Ties keep the existing value.
  - `cur_otr` is the OR of `r_otr` over the window.
  - The sample counter runs 0..`WINDOW`-1 and wraps to 0 on DONE.
- Arithmetic: `amp_pp` is a 14-bit unsigned subtraction. `peak_max >= peak_min` always holds, so no underflow is possible.
- Output hold: `peak_max`, `peak_min`, `amp_pp` and `otr_flag` change only in DONE. Between DONE cycles they hold their values, including while in IDLE.
- `meas_en` dropping in SETTLE or MEASURE: return to IDLE at the next edge. The partial window is discarded, there is no `meas_valid`, and the outputs hold.
- `meas_en` dropping in DONE: DONE still completes and strobes `meas_valid`, then the block enters IDLE.
- Reset (`ADC_rst_n`=0 at an edge, in any state):
  - State goes to IDLE and all counters to 0.
  - All outputs go to 0: `peak_max`, `peak_min`, `amp_pp`, `otr_flag`, `meas_valid` and `busy`.
  - `r_adc` goes to 0.
  - Reset has priority over all other events.

## Timing
- Input capture: a sample presented at edge e is registered at e and enters the window compare at e+1.
- Output latency: for the last sample of a window presented at edge e, outputs and `meas_valid` are high in the cycle following edge e+2.
- Window cadence: in continuous running, `meas_valid` pulses every `WINDOW`+1 cycles, because DONE costs one cycle.
- DONE-cycle sample: the sample registered during DONE is not used.
- First window: the first `meas_valid` arrives `1 + SETTLE_CYC + WINDOW + 1` cycles after `meas_en` is first sampled high in IDLE. This is 118 cycles at the default parameters.
- `busy`: registered; rises the cycle after the IDLE→SETTLE transition edge.

## Configuration
- `JH_ADC_AVG_EN` defined:
  - `amp_pp` is the mean of the last 4 window peak-to-peak values: a 16-bit sum shifted right by 2, truncated.
  - `meas_valid` and all outputs update only on every 4th DONE.
  - `peak_max`, `peak_min` and `otr_flag` reflect the 4th window only.
  - The group counter clears on reset and whenever the block enters IDLE.
- `JH_ADC_AVG_EN` undefined: `amp_pp` is the per-window value, and every DONE updates the outputs.

## Test plan
- Constant input: `ADC_in`=8192 with `meas_en`=1 → `peak_max`=`peak_min`=8192 and `amp_pp`=0. First `meas_valid` after 118 cycles, then every 101 cycles.
- Full-scale sine: the 100-entry full-scale sine table (0..16383), one sample per clock → `peak_max`=16383, `peak_min`=0, `amp_pp`=16383.
- Overrange: single-cycle `ADC_OTR`=1 at window sample 50 → `otr_flag`=1 for that window and 0 for the next window.
- Abort mid-window: `meas_en` dropped at window sample 60 → no `meas_valid`, outputs unchanged, `busy`=0 two edges later. Re-enable → full 118-cycle start-up again.
- Reset mid-window: `ADC_rst_n`=0 for one edge at sample 40 → all outputs 0 the next cycle, state IDLE.
- With `JH_ADC_AVG_EN` defined: four windows with per-window peak-to-peak 100, 200, 300, 401 → a single `meas_valid` with `amp_pp`=250.
